// File: rtl/edge_event_arbiter.sv
// Multi-channel edge-event scheduler: per-channel rise/fall detection, one pending
// event per channel, round-robin arbitration onto a single valid/ready event port.
module edge_event_arbiter #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  din,
  input  logic [N_CH-1:0]  cfg_rise_en,
  input  logic [N_CH-1:0]  cfg_fall_en,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [IDX_W-1:0] evt_ch,
  output logic             evt_rise,
  output logic [N_CH-1:0]  ovf,
  input  logic [N_CH-1:0]  ovf_clr
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_VALID = 1'b1
  } state_t;

  state_t             state_q;
  logic [N_CH-1:0]    din_q;
  logic [N_CH-1:0]    pend_q, pend_d;
  logic [N_CH-1:0]    pend_rise_q, pend_rise_d;
  logic [N_CH-1:0]    ovf_q, ovf_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   evt_ch_q;
  logic               evt_rise_q;

  logic [N_CH-1:0]    rise, fall, edge_any;
  logic [N_CH-1:0]    gnt_oh, ovf_set;
  logic               gnt_en, gnt_vld;
  logic [IDX_W-1:0]   gnt_idx, scan_idx;

  assign evt_valid = (state_q == S_VALID);
  assign evt_ch    = evt_ch_q;
  assign evt_rise  = evt_rise_q;
  assign ovf       = ovf_q;

  assign rise     = din & ~din_q & cfg_rise_en;
  assign fall     = ~din & din_q & cfg_fall_en;
  assign edge_any = rise | fall;
  assign gnt_en   = ~evt_valid | evt_ready;

  // Round-robin: first registered pend at or after rr_ptr, index arithmetic wraps mod N_CH.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      scan_idx = rr_ptr_q + IDX_W'(k);
      if (!gnt_vld && pend_q[scan_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = scan_idx;
      end
    end
    gnt_vld = gnt_vld & gnt_en;
  end

  always_comb begin
    gnt_oh = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      gnt_oh[i] = gnt_vld && (gnt_idx == IDX_W'(i));
    end
  end

  // A new edge on a channel being granted this cycle replaces the slot; otherwise oldest wins.
  always_comb begin
    pend_d      = pend_q;
    pend_rise_d = pend_rise_q;
    ovf_set     = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (edge_any[i]) begin
        if (!pend_q[i] || gnt_oh[i]) begin
          pend_d[i]      = 1'b1;
          pend_rise_d[i] = rise[i];
        end else begin
          ovf_set[i] = 1'b1;
        end
      end else if (gnt_oh[i]) begin
        pend_d[i] = 1'b0;
      end
    end
    ovf_d    = (ovf_q & ~ovf_clr) | ovf_set;
    rr_ptr_d = gnt_vld ? gnt_idx + IDX_W'(1) : rr_ptr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      din_q       <= '0;
      pend_q      <= '0;
      pend_rise_q <= '0;
      ovf_q       <= '0;
      rr_ptr_q    <= '0;
    end else begin
      din_q       <= din;
      pend_q      <= pend_d;
      pend_rise_q <= pend_rise_d;
      ovf_q       <= ovf_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  // Output slot: accepting and reloading happen in the same cycle for back-to-back events.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      evt_ch_q   <= '0;
      evt_rise_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (gnt_vld) begin
            state_q    <= S_VALID;
            evt_ch_q   <= gnt_idx;
            evt_rise_q <= pend_rise_q[gnt_idx];
          end
        end
        S_VALID: begin
          if (evt_ready) begin
            if (gnt_vld) begin
              evt_ch_q   <= gnt_idx;
              evt_rise_q <= pend_rise_q[gnt_idx];
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter: vector table plus hand-written
// sequences for reset, overflow, back-to-back reload and fairness.
module tb_edge_event_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] din, cfg_rise_en, cfg_fall_en, ovf, ovf_clr;
  logic       evt_valid, evt_ready, evt_rise;
  logic [1:0] evt_ch;

  int unsigned checks = 0;
  int unsigned errors = 0;

  edge_event_arbiter #(.N_CH(4), .IDX_W(2)) dut (
    .clk(clk), .rst(rst), .din(din), .cfg_rise_en(cfg_rise_en),
    .cfg_fall_en(cfg_fall_en), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_ch(evt_ch), .evt_rise(evt_rise), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] din;
    logic [3:0] ren;
    logic [3:0] fen;
    logic       rdy;
    logic       ev;
    logic [1:0] ch;
    logic       rs;
  } vec_t;

  vec_t vecs[30];
  int unsigned nvec = 0;

  task automatic add(input logic [3:0] d, input logic [3:0] r, input logic [3:0] f,
                     input logic rd, input logic e, input logic [1:0] c, input logic rs);
    vecs[nvec].din = d; vecs[nvec].ren = r; vecs[nvec].fen = f; vecs[nvec].rdy = rd;
    vecs[nvec].ev = e; vecs[nvec].ch = c; vecs[nvec].rs = rs;
    nvec++;
  endtask

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] d);
    rst = 1'b1;
    din = d;
    cfg_rise_en = 4'hF;
    cfg_fall_en = 4'hF;
    evt_ready = 1'b1;
    ovf_clr = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  int unsigned nev, ch2_at, ch2_cnt, ch0_cnt;

  initial begin
    rst = 1'b1;
    din = '0; cfg_rise_en = 4'hF; cfg_fall_en = 4'hF; evt_ready = 1'b1; ovf_clr = '0;

    // All-edges burst, rr_ptr from 0, wraps back to 0
    add(4'b1111, 4'hF, 4'hF, 1, 0, 0, 0);
    add(4'b1111, 4'hF, 4'hF, 1, 1, 0, 1);
    add(4'b1111, 4'hF, 4'hF, 1, 1, 1, 1);
    add(4'b1111, 4'hF, 4'hF, 1, 1, 2, 1);
    add(4'b1111, 4'hF, 4'hF, 1, 1, 3, 1);
    add(4'b1111, 4'hF, 4'hF, 1, 0, 0, 0);
    add(4'b0000, 4'hF, 4'hF, 1, 0, 0, 0);
    add(4'b0000, 4'hF, 4'hF, 1, 1, 0, 0);
    add(4'b0000, 4'hF, 4'hF, 1, 1, 1, 0);
    add(4'b0000, 4'hF, 4'hF, 1, 1, 2, 0);
    add(4'b0000, 4'hF, 4'hF, 1, 1, 3, 0);
    add(4'b0000, 4'hF, 4'hF, 1, 0, 0, 0);
    // Single rise, two-cycle latency, one-cycle event
    add(4'b0001, 4'hF, 4'hF, 1, 0, 0, 0);
    add(4'b0001, 4'hF, 4'hF, 1, 1, 0, 1);
    add(4'b0001, 4'hF, 4'hF, 1, 0, 0, 0);
    add(4'b0000, 4'hF, 4'hF, 1, 0, 0, 0);
    add(4'b0000, 4'hF, 4'hF, 1, 1, 0, 0);
    add(4'b0000, 4'hF, 4'hF, 1, 0, 0, 0);
    // Fall-only on ch3 pulse
    add(4'b1000, 4'h0, 4'hF, 1, 0, 0, 0);
    add(4'b0000, 4'h0, 4'hF, 1, 0, 0, 0);
    add(4'b0000, 4'h0, 4'hF, 1, 1, 3, 0);
    add(4'b0000, 4'h0, 4'hF, 1, 0, 0, 0);
    add(4'b0000, 4'h0, 4'hF, 1, 0, 0, 0);
    // Both enables off: nothing
    add(4'b0100, 4'h0, 4'h0, 1, 0, 0, 0);
    add(4'b0000, 4'h0, 4'h0, 1, 0, 0, 0);
    add(4'b0000, 4'h0, 4'h0, 1, 0, 0, 0);
    // Stall holds the presented event
    add(4'b0010, 4'hF, 4'hF, 0, 0, 0, 0);
    add(4'b0010, 4'hF, 4'hF, 0, 1, 1, 1);
    add(4'b0010, 4'hF, 4'hF, 0, 1, 1, 1);
    add(4'b0010, 4'hF, 4'hF, 1, 0, 0, 0);

    #2;
    check("rst_valid", evt_valid, 0);
    check("rst_ch", evt_ch, 0);
    check("rst_rise", evt_rise, 0);
    check("rst_ovf", ovf, 0);
    do_reset(4'b0000);

    for (int unsigned v = 0; v < nvec; v++) begin
      din = vecs[v].din; cfg_rise_en = vecs[v].ren; cfg_fall_en = vecs[v].fen;
      evt_ready = vecs[v].rdy;
      cyc();
      check($sformatf("vec%0d_valid", v), evt_valid, vecs[v].ev);
      if (vecs[v].ev) begin
        check($sformatf("vec%0d_ch", v), evt_ch, vecs[v].ch);
        check($sformatf("vec%0d_rise", v), evt_rise, vecs[v].rs);
      end
      check($sformatf("vec%0d_ovf", v), ovf, 0);
    end

    // Overflow, sticky clear, set-over-clear priority, back-to-back reload
    do_reset(4'b0000);
    evt_ready = 1'b0;
    din = 4'b0010; cyc(); cyc();
    din = 4'b0000; cyc();
    check("ovf_none_yet", ovf, 0);
    din = 4'b0010; cyc();
    check("ovf_set", ovf, 4'b0010);
    check("ovf_hold_valid", evt_valid, 1);
    check("ovf_hold_ch", evt_ch, 1);
    check("ovf_hold_rise", evt_rise, 1);
    ovf_clr = 4'b0010; cyc();
    check("ovf_clr", ovf, 0);
    din = 4'b0000; cyc();
    check("ovf_set_over_clr", ovf, 4'b0010);
    ovf_clr = '0; evt_ready = 1'b1; cyc();
    check("b2b_valid", evt_valid, 1);
    check("b2b_ch", evt_ch, 1);
    check("b2b_rise", evt_rise, 0);
    cyc();
    check("b2b_drain", evt_valid, 0);

    // Async reset mid-VALID with ch2 pending
    do_reset(4'b0000);
    evt_ready = 1'b0;
    din = 4'b0001; cyc();
    din = 4'b0101; cyc(); cyc();
    check("pre_rst_valid", evt_valid, 1);
    check("pre_rst_ch", evt_ch, 0);
    #3 rst = 1'b1;
    #1;
    check("async_rst_valid", evt_valid, 0);
    din = 4'b0000;
    @(posedge clk); #1 rst = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      cyc();
      check($sformatf("post_rst_quiet%0d", i), evt_valid, 0);
    end
    // Channel high at reset release gives a rising edge
    rst = 1'b1; din = 4'b0100;
    @(posedge clk); #1 rst = 1'b0;
    cyc();
    check("release_high_lat1", evt_valid, 0);
    cyc();
    check("release_high_valid", evt_valid, 1);
    check("release_high_ch", evt_ch, 2);
    check("release_high_rise", evt_rise, 1);

    // Fairness: ch0 toggling every cycle must not starve ch2
    do_reset(4'b0000);
    nev = 0; ch2_at = 0; ch2_cnt = 0; ch0_cnt = 0;
    din = 4'b0101; cyc();
    for (int unsigned i = 0; i < 10; i++) begin
      din[0] = ~din[0];
      cyc();
      if (evt_valid) begin
        nev++;
        if (evt_ch == 2) begin
          ch2_cnt++;
          if (ch2_at == 0) ch2_at = nev;
        end
        if (evt_ch == 0) ch0_cnt++;
      end
    end
    check("fair_ch2_within2", (ch2_at >= 1 && ch2_at <= 2), 1);
    check("fair_ch2_once", ch2_cnt, 1);
    check("fair_ch0_served", ch0_cnt >= 4, 1);
    check("fair_one_per_cycle", nev, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
